// File: rtl/plic_claim_agent.sv
// plic_claim_agent: claims PLIC interrupts for one target, hands IDs to a local consumer, then completes them
module plic_claim_agent #(
    parameter logic [31:0] BASE_ADDR     = 32'h0C00_0000,
    parameter int          TARGET_ID     = 0,
    parameter int          ID_WIDTH      = 5,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                eip_i,
    output logic [31:0]         reg_addr_o,
    output logic                reg_write_o,
    output logic [31:0]         reg_wdata_o,
    output logic [3:0]          reg_wstrb_o,
    output logic                reg_valid_o,
    input  logic [31:0]         reg_rdata_i,
    input  logic                reg_error_i,
    input  logic                reg_ready_i,
    output logic [ID_WIDTH-1:0] irq_id_o,
    output logic                irq_valid_o,
    input  logic                irq_ready_i,
    input  logic                done_i,
    output logic                busy_o,
    output logic                err_o,
    output logic [15:0]         claim_cnt_o,
    output logic [7:0]          spurious_cnt_o
);
    typedef enum logic [2:0] {IDLE, CLAIM, DELIVER, SERVICE, COMPLETE, SETTLE} state_t;

    localparam logic [31:0] CC_ADDR = BASE_ADDR + 32'h0020_0004 + 32'(TARGET_ID) * 32'h0000_1000;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t              state;
    logic [SW-1:0]       settle_cnt;
    logic [ID_WIDTH-1:0] rd_id;
    logic                unused_rdata;

    assign rd_id        = reg_rdata_i[ID_WIDTH-1:0];
    assign unused_rdata = ^reg_rdata_i[31:ID_WIDTH];

    // claim / deliver / service / complete / settle sequencer; every output is set on the edge that enters its state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            reg_addr_o     <= '0;
            reg_write_o    <= 1'b0;
            reg_wdata_o    <= '0;
            reg_wstrb_o    <= '0;
            reg_valid_o    <= 1'b0;
            irq_id_o       <= '0;
            irq_valid_o    <= 1'b0;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
            claim_cnt_o    <= '0;
            spurious_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: if (enable_i && eip_i) begin
                    state       <= CLAIM;
                    busy_o      <= 1'b1;
                    reg_valid_o <= 1'b1;
                    reg_write_o <= 1'b0;
                    reg_addr_o  <= CC_ADDR;
                    reg_wdata_o <= '0;
                    reg_wstrb_o <= 4'h0;
                end
                CLAIM: if (reg_ready_i) begin
                    reg_valid_o <= 1'b0;
                    if (reg_error_i) begin
                        err_o      <= 1'b1;
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LAST;
                    end else if (rd_id == '0) begin
                        spurious_cnt_o <= (spurious_cnt_o == 8'hFF) ? spurious_cnt_o : spurious_cnt_o + 8'd1;
                        state          <= SETTLE;
                        settle_cnt     <= SETTLE_LAST;
                    end else begin
                        irq_id_o    <= rd_id;
                        irq_valid_o <= 1'b1;
                        claim_cnt_o <= claim_cnt_o + 16'd1;
                        state       <= DELIVER;
                    end
                end
                DELIVER: if (irq_ready_i) begin
                    irq_valid_o <= 1'b0;
                    state       <= SERVICE;
                end
                SERVICE: if (done_i) begin
                    state       <= COMPLETE;
                    reg_valid_o <= 1'b1;
                    reg_write_o <= 1'b1;
                    reg_wdata_o <= 32'(irq_id_o);
                    reg_wstrb_o <= 4'hF;
                end
                COMPLETE: if (reg_ready_i) begin
                    reg_valid_o <= 1'b0;
                    err_o       <= reg_error_i;
                    state       <= SETTLE;
                    settle_cnt  <= SETTLE_LAST;
                end
                SETTLE: if (settle_cnt == '0) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end else begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plic_claim_agent.sv
// tb_plic_claim_agent: directed self-checking bench for plic_claim_agent
module tb_plic_claim_agent;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, eip = 1'b0;
    logic        rerr = 1'b0, rready = 1'b0, irq_ready = 1'b0, done = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic [4:0]  id0, id1;
    logic [15:0] ccnt0, ccnt1;
    logic [7:0]  scnt0, scnt1;
    logic        write0, valid0, ivalid0, busy0, err0;
    logic        write1, valid1, ivalid1, busy1, err1;
    int          checks = 0, errors = 0;
    int          rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0, errp0 = 0, hs0 = 0;

    plic_claim_agent dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .eip_i(eip),
        .reg_addr_o(addr0), .reg_write_o(write0), .reg_wdata_o(wdata0), .reg_wstrb_o(wstrb0),
        .reg_valid_o(valid0), .reg_rdata_i(rdata), .reg_error_i(rerr), .reg_ready_i(rready),
        .irq_id_o(id0), .irq_valid_o(ivalid0), .irq_ready_i(irq_ready), .done_i(done),
        .busy_o(busy0), .err_o(err0), .claim_cnt_o(ccnt0), .spurious_cnt_o(scnt0)
    );

    plic_claim_agent #(.TARGET_ID(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .eip_i(eip),
        .reg_addr_o(addr1), .reg_write_o(write1), .reg_wdata_o(wdata1), .reg_wstrb_o(wstrb1),
        .reg_valid_o(valid1), .reg_rdata_i(rdata), .reg_error_i(rerr), .reg_ready_i(rready),
        .irq_id_o(id1), .irq_valid_o(ivalid1), .irq_ready_i(irq_ready), .done_i(done),
        .busy_o(busy1), .err_o(err1), .claim_cnt_o(ccnt1), .spurious_cnt_o(scnt1)
    );

    always #5 clk = ~clk;

    // transfer, error-pulse and delivery counters observed on the clock edge
    always @(posedge clk) begin
        if (!rst) begin
            if (valid0 && rready) begin if (write0) wr0++; else rd0++; end
            if (valid1 && rready) begin if (write1) wr1++; else rd1++; end
            if (err0) errp0++;
            if (ivalid0 && irq_ready) hs0++;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; enable = 0; eip = 0; rerr = 0; rready = 0; irq_ready = 0; done = 0; rdata = '0;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        step; step;
        checks++; if ({valid0, write0, ivalid0, busy0, err0} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {valid0, write0, ivalid0, busy0, err0}); end
        checks++; if ({addr0, wdata0, wstrb0, id0} !== 73'b0) begin errors++; $display("FAIL reset_data: got %h expected 0", {addr0, wdata0, wstrb0, id0}); end
        checks++; if ({ccnt0, scnt0} !== 24'b0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", {ccnt0, scnt0}); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int r, w;
        do_reset; r = rd0; w = wr0;
        enable = 1; eip = 1; rready = 1; rdata = 32'h7; irq_ready = 1;
        step; eip = 0;
        checks++; if ({valid0, write0, wstrb0, addr0, busy0} !== {1'b1, 1'b0, 4'h0, 32'h0C20_0004, 1'b1}) begin errors++; $display("FAIL basic_read: got %h expected %h", {valid0, write0, wstrb0, addr0, busy0}, {1'b1, 1'b0, 4'h0, 32'h0C20_0004, 1'b1}); end
        step;
        checks++; if ({ivalid0, id0, valid0, ccnt0} !== {1'b1, 5'd7, 1'b0, 16'd1}) begin errors++; $display("FAIL basic_deliver: got %h expected %h", {ivalid0, id0, valid0, ccnt0}, {1'b1, 5'd7, 1'b0, 16'd1}); end
        step;
        checks++; if (ivalid0 !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b expected 0", ivalid0); end
        repeat (4) step;
        done = 1; step; done = 0;
        checks++; if ({valid0, write0, wdata0, wstrb0, addr0} !== {1'b1, 1'b1, 32'h7, 4'hF, 32'h0C20_0004}) begin errors++; $display("FAIL basic_write: got %h expected %h", {valid0, write0, wdata0, wstrb0, addr0}, {1'b1, 1'b1, 32'h7, 4'hF, 32'h0C20_0004}); end
        step;
        checks++; if ({valid0, busy0} !== 2'b01) begin errors++; $display("FAIL basic_settle1: got %b expected 01", {valid0, busy0}); end
        step;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_settle2: got %b expected 1", busy0); end
        step;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy0); end
        checks++; if (rd0 - r != 1 || wr0 - w != 1) begin errors++; $display("FAIL basic_xfers: got rd=%0d wr=%0d expected 1 1", rd0 - r, wr0 - w); end
    endtask

    task automatic test_spurious;
        int w, h;
        do_reset; w = wr0; h = hs0;
        enable = 1; eip = 1; rready = 1; rdata = 32'hFFFF_FFE0; irq_ready = 1;
        step; eip = 0;
        step;
        checks++; if ({ivalid0, valid0, scnt0, ccnt0} !== {1'b0, 1'b0, 8'd1, 16'd0}) begin errors++; $display("FAIL spur_one: got %h expected %h", {ivalid0, valid0, scnt0, ccnt0}, {1'b0, 1'b0, 8'd1, 16'd0}); end
        step; step;
        checks++; if (busy0 !== 1'b0 || wr0 != w || hs0 != h) begin errors++; $display("FAIL spur_nowrite: got busy=%b wr=%0d hs=%0d expected 0 0 0", busy0, wr0 - w, hs0 - h); end
        eip = 1;
        repeat (1200) step;
        eip = 0;
        repeat (4) step;
        checks++; if ({scnt0, ccnt0, busy0} !== {8'd255, 16'd0, 1'b0}) begin errors++; $display("FAIL spur_sat: got %h expected %h", {scnt0, ccnt0, busy0}, {8'd255, 16'd0, 1'b0}); end
    endtask

    task automatic test_back_pressure;
        int r, w;
        do_reset; r = rd1; w = wr1;
        enable = 1; eip = 1; rready = 0; rdata = 32'hFFFF_FFE9; irq_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step; eip = 0;
            checks++; if ({valid1, write1, addr1} !== {1'b1, 1'b0, 32'h0C20_1004}) begin errors++; $display("FAIL bp_read_hold: got %h expected %h", {valid1, write1, addr1}, {1'b1, 1'b0, 32'h0C20_1004}); end
        end
        rready = 1; step; rready = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({ivalid1, id1, valid1} !== {1'b1, 5'd9, 1'b0}) begin errors++; $display("FAIL bp_irq_hold: got %h expected %h", {ivalid1, id1, valid1}, {1'b1, 5'd9, 1'b0}); end
            step;
        end
        irq_ready = 1; step; irq_ready = 0;
        checks++; if (ivalid1 !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b expected 0", ivalid1); end
        done = 1; step; done = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({valid1, write1, addr1, wdata1, wstrb1} !== {1'b1, 1'b1, 32'h0C20_1004, 32'h9, 4'hF}) begin errors++; $display("FAIL bp_write_hold: got %h expected %h", {valid1, write1, addr1, wdata1, wstrb1}, {1'b1, 1'b1, 32'h0C20_1004, 32'h9, 4'hF}); end
            step;
        end
        rready = 1; step; rready = 0;
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL bp_write_drop: got %b expected 0", valid1); end
        step; step;
        checks++; if (busy1 !== 1'b0 || rd1 - r != 1 || wr1 - w != 1) begin errors++; $display("FAIL bp_xfers: got busy=%b rd=%0d wr=%0d expected 0 1 1", busy1, rd1 - r, wr1 - w); end
    endtask

    task automatic test_errors;
        int e, w, h;
        do_reset; e = errp0; w = wr0; h = hs0;
        enable = 1; eip = 1; rready = 1; rerr = 1; rdata = 32'h5; irq_ready = 1;
        step; eip = 0;
        step; rerr = 0;
        checks++; if ({err0, ivalid0, ccnt0} !== {1'b1, 1'b0, 16'd0}) begin errors++; $display("FAIL err_claim: got %h expected %h", {err0, ivalid0, ccnt0}, {1'b1, 1'b0, 16'd0}); end
        step;
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_claim_pulse: got %b expected 0", err0); end
        step;
        checks++; if (busy0 !== 1'b0 || errp0 - e != 1 || wr0 != w || hs0 != h) begin errors++; $display("FAIL err_claim_end: got busy=%b errs=%0d wr=%0d hs=%0d expected 0 1 0 0", busy0, errp0 - e, wr0 - w, hs0 - h); end
        do_reset; e = errp0;
        enable = 1; eip = 1; rready = 1; rdata = 32'h3; irq_ready = 1;
        step; eip = 0;
        step;
        checks++; if ({ivalid0, id0} !== {1'b1, 5'd3}) begin errors++; $display("FAIL err_cpl_deliver: got %h expected %h", {ivalid0, id0}, {1'b1, 5'd3}); end
        step; done = 1; rerr = 1;
        step; done = 0;
        checks++; if ({valid0, write0, err0} !== 3'b110) begin errors++; $display("FAIL err_cpl_write: got %b expected 110", {valid0, write0, err0}); end
        step; rerr = 0;
        checks++; if ({err0, valid0} !== 2'b10) begin errors++; $display("FAIL err_cpl_pulse: got %b expected 10", {err0, valid0}); end
        step;
        checks++; if ({err0, busy0} !== 2'b01) begin errors++; $display("FAIL err_cpl_settle: got %b expected 01", {err0, busy0}); end
        step;
        checks++; if (busy0 !== 1'b0 || errp0 - e != 1 || ccnt0 !== 16'd1) begin errors++; $display("FAIL err_cpl_idle: got busy=%b errs=%0d cnt=%0d expected 0 1 1", busy0, errp0 - e, ccnt0); end
    endtask

    task automatic test_enable_stray_done;
        int r;
        do_reset; r = rd0;
        enable = 0; eip = 1; rready = 1; rdata = 32'h4; irq_ready = 0;
        repeat (3) step;
        done = 1; step; done = 0; step;
        checks++; if ({valid0, busy0, ivalid0} !== 3'b0 || rd0 != r) begin errors++; $display("FAIL en_gate: got %b rd=%0d expected 000 0", {valid0, busy0, ivalid0}, rd0 - r); end
        enable = 1;
        step; eip = 0; enable = 0;
        checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL en_claim: got %b expected 1", valid0); end
        step; done = 1;
        checks++; if ({ivalid0, id0} !== {1'b1, 5'd4}) begin errors++; $display("FAIL en_deliver: got %h expected %h", {ivalid0, id0}, {1'b1, 5'd4}); end
        step; done = 0;
        checks++; if ({ivalid0, valid0} !== 2'b10) begin errors++; $display("FAIL stray_deliver: got %b expected 10", {ivalid0, valid0}); end
        irq_ready = 1; step; irq_ready = 0;
        repeat (3) step;
        checks++; if ({ivalid0, valid0, busy0} !== 3'b001) begin errors++; $display("FAIL stray_service: got %b expected 001", {ivalid0, valid0, busy0}); end
        done = 1; step; done = 0;
        checks++; if ({valid0, write0, wdata0} !== {1'b1, 1'b1, 32'h4}) begin errors++; $display("FAIL en_complete: got %h expected %h", {valid0, write0, wdata0}, {1'b1, 1'b1, 32'h4}); end
        step; step; step;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL en_idle: got %b expected 0", busy0); end
    endtask

    task automatic test_wrap;
        do_reset;
        force dut0.claim_cnt_o = 16'hFFFF;
        step;
        release dut0.claim_cnt_o;
        enable = 1; eip = 1; rready = 1; rdata = 32'h2; irq_ready = 1;
        step; eip = 0;
        step;
        checks++; if ({ccnt0, id0, ivalid0} !== {16'd0, 5'd2, 1'b1}) begin errors++; $display("FAIL wrap: got %h expected %h", {ccnt0, id0, ivalid0}, {16'd0, 5'd2, 1'b1}); end
        step; done = 1; step; done = 0;
        step; step; step;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b expected 0", busy0); end
    endtask

    task automatic test_reset_mid_op;
        do_reset;
        enable = 1; eip = 1; rready = 1; rdata = 32'h8; irq_ready = 1;
        step; eip = 0; step; step;
        checks++; if ({busy0, ivalid0, ccnt0} !== {1'b1, 1'b0, 16'd1}) begin errors++; $display("FAIL rmid_service: got %h expected %h", {busy0, ivalid0, ccnt0}, {1'b1, 1'b0, 16'd1}); end
        rst = 1; step; rst = 0;
        checks++; if ({valid0, write0, ivalid0, busy0, err0, addr0, wdata0, wstrb0, id0, ccnt0, scnt0} !== 102'b0) begin errors++; $display("FAIL rmid_service_rst: got %h expected 0", {valid0, write0, ivalid0, busy0, err0, addr0, wdata0, wstrb0, id0, ccnt0, scnt0}); end
        eip = 1; rready = 0;
        step; eip = 0; step;
        checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL rmid_claim_wait: got %b expected 1", valid0); end
        rst = 1; step; rst = 0;
        checks++; if ({valid0, write0, ivalid0, busy0, err0, addr0, wdata0, wstrb0, id0, ccnt0, scnt0} !== 102'b0) begin errors++; $display("FAIL rmid_claim_rst: got %h expected 0", {valid0, write0, ivalid0, busy0, err0, addr0, wdata0, wstrb0, id0, ccnt0, scnt0}); end
        eip = 1; rready = 1; rdata = 32'h6; irq_ready = 1;
        step; eip = 0;
        step;
        checks++; if ({ivalid0, id0, ccnt0} !== {1'b1, 5'd6, 16'd1}) begin errors++; $display("FAIL rmid_fresh: got %h expected %h", {ivalid0, id0, ccnt0}, {1'b1, 5'd6, 16'd1}); end
        step; done = 1; step; done = 0;
        checks++; if ({valid0, write0, wdata0} !== {1'b1, 1'b1, 32'h6}) begin errors++; $display("FAIL rmid_fresh_write: got %h expected %h", {valid0, write0, wdata0}, {1'b1, 1'b1, 32'h6}); end
        step; step; step;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_fresh_idle: got %b expected 0", busy0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_spurious;
        test_back_pressure;
        test_errors;
        test_enable_stray_done;
        test_wrap;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
